// File: rtl/serial_tx_ctrl.sv
// Transmit control FSM for an 8051-style serial port: sequences load/shift/stop/TI.
// Optional macro SERIAL_TX_CTRL_TI_GUARD_EN blocks new frames while TI is still set.
module serial_tx_ctrl (
  input  logic serial_clock_i,
  input  logic serial_reset_i_b,
  input  logic serial_br_i,
  input  logic serial_scon7_sm0_i,
  input  logic serial_scon1_ti_i,
  input  logic serial_end_bit_i,
  input  logic serial_serial_tx_i,
  output logic serial_p3en_0_o,
  output logic serial_p3en_1_o,
  output logic serial_data_en_o,
  output logic serial_scon1_ti_o,
  output logic serial_send_o,
  output logic serial_shift_o,
  output logic serial_stop_bit_gen_o,
  output logic serial_start_shifter_reg_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    SHIFT = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   go_s;
  logic   p3en_0_d, p3en_1_d, data_en_d, ti_d, send_d, shift_d, stop_d, start_d;

`ifdef SERIAL_TX_CTRL_TI_GUARD_EN
  assign go_s = serial_serial_tx_i & ~serial_scon1_ti_i;
`else
  logic unused_ti_s;
  assign unused_ti_s = serial_scon1_ti_i;
  assign go_s        = serial_serial_tx_i;
`endif

  // Next state, mode latch and the one-clock shift strobe.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shift_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d = LOAD;
          mode_d  = serial_scon7_sm0_i;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (mode_q) state_d = START;
        else        state_d = SHIFT;
      end
      START: begin
        if (serial_br_i) state_d = SHIFT;
        else             state_d = START;
      end
      SHIFT: begin
        // end_bit takes priority over a shift on the same tick
        if (serial_br_i && serial_end_bit_i) begin
          state_d = mode_q ? STOP : DONE;
        end else if (serial_br_i) begin
          shift_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      STOP: begin
        if (serial_br_i) state_d = DONE;
        else             state_d = STOP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign p3en_0_d  = (state_d != IDLE) & ~mode_d;
  assign p3en_1_d  = (state_d != IDLE);
  assign data_en_d = (state_d == SHIFT);
  assign ti_d      = (state_d == DONE);
  assign send_d    = (state_d == START) | (state_d == SHIFT) | (state_d == STOP);
  assign stop_d    = (state_d == STOP);
  assign start_d   = (state_d == LOAD);

  // State, mode and registered Moore outputs.
  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i_b) begin
      state_q                    <= IDLE;
      mode_q                     <= 1'b0;
      serial_p3en_0_o            <= 1'b0;
      serial_p3en_1_o            <= 1'b0;
      serial_data_en_o           <= 1'b0;
      serial_scon1_ti_o          <= 1'b0;
      serial_send_o              <= 1'b0;
      serial_shift_o             <= 1'b0;
      serial_stop_bit_gen_o      <= 1'b0;
      serial_start_shifter_reg_o <= 1'b0;
    end else begin
      state_q                    <= state_d;
      mode_q                     <= mode_d;
      serial_p3en_0_o            <= p3en_0_d;
      serial_p3en_1_o            <= p3en_1_d;
      serial_data_en_o           <= data_en_d;
      serial_scon1_ti_o          <= ti_d;
      serial_send_o              <= send_d;
      serial_shift_o             <= shift_d;
      serial_stop_bit_gen_o      <= stop_d;
      serial_start_shifter_reg_o <= start_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: each frame's output timeline is planned
// up front from the baud-tick pattern, then compared cycle by cycle.
module tb_serial_tx_ctrl;

  logic clk = 1'b0;
  logic rst, br, sm0, ti_i, end_bit, tx;
  logic p3en_0, p3en_1, data_en, ti_o, send, shift, stop, start;
  logic [7:0] outs;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_START = 2;
  localparam int P_SHIFT = 3;
  localparam int P_STOP  = 4;
  localparam int P_DONE  = 5;

  always #5 clk = ~clk;

  serial_tx_ctrl dut (
    .serial_clock_i            (clk),
    .serial_reset_i_b          (rst),
    .serial_br_i               (br),
    .serial_scon7_sm0_i        (sm0),
    .serial_scon1_ti_i         (ti_i),
    .serial_end_bit_i          (end_bit),
    .serial_serial_tx_i        (tx),
    .serial_p3en_0_o           (p3en_0),
    .serial_p3en_1_o           (p3en_1),
    .serial_data_en_o          (data_en),
    .serial_scon1_ti_o         (ti_o),
    .serial_send_o             (send),
    .serial_shift_o            (shift),
    .serial_stop_bit_gen_o     (stop),
    .serial_start_shifter_reg_o(start)
  );

  assign outs = {p3en_0, p3en_1, data_en, ti_o, send, shift, stop, start};

  function automatic logic [7:0] expv(input int ph, input logic m, input logic sh);
    logic [7:0] v;
    v = 8'd0;
    if (ph != P_IDLE) begin
      v[7] = ~m;
      v[6] = 1'b1;
    end
    v[5] = (ph == P_SHIFT);
    v[4] = (ph == P_DONE);
    v[3] = (ph == P_START) || (ph == P_SHIFT) || (ph == P_STOP);
    v[2] = sh;
    v[1] = (ph == P_STOP);
    v[0] = (ph == P_LOAD);
    return v;
  endfunction

  task automatic tick_check(input logic [7:0] exp, input string tag);
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, outs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tx      = 1'b0;
      rst     = 1'b0;
      br      = 1'($urandom_range(0, 1));
      end_bit = 1'($urandom_range(0, 1));
      sm0     = 1'($urandom_range(0, 1));
      ti_i    = 1'($urandom_range(0, 1));
      tick_check(8'd0, "idle");
    end
  endtask

  // style 0: br every 2nd clock; style 1: random ticks
  task automatic run_frame(input logic m, input int style, input bit busy,
                           input bit strobe_in_done, input int rst_at, input logic ti0);
    logic brv [0:399];
    int   ph  [0:399];
    logic shp [0:399];
    int   b[$];
    int   a, e, d, last, rst_e, k;
    for (int i = 0; i < 400; i++) begin
      brv[i] = (style == 0) ? (i % 2 == 0) : ((i % 8 == 0) || 1'($urandom_range(0, 1)));
      ph[i]  = P_IDLE;
      shp[i] = 1'b0;
    end
    ph[0] = P_LOAD;
    if (m) begin
      e = 2;
      while (!brv[e]) e++;
      for (int i = 1; i < e; i++) ph[i] = P_START;
      a = e;
    end else begin
      a = 1;
    end
    ph[a] = P_SHIFT;
    k = a + 1;
    while (b.size() < (m ? 10 : 9)) begin
      if (brv[k]) b.push_back(k);
      k++;
    end
    for (int i = a + 1; i < b[8]; i++) ph[i] = P_SHIFT;
    for (int i = 0; i < 8; i++) shp[b[i]] = 1'b1;
    if (m) begin
      for (int i = b[8]; i < b[9]; i++) ph[i] = P_STOP;
      d = b[9];
    end else begin
      d = b[8];
    end
    ph[d]  = P_DONE;
    last   = d + 1;
    rst_e  = (rst_at >= 0) ? b[rst_at] : -1;
    for (int i = 0; i <= last; i++) begin
      tx      = (i == 0) || (busy && i == b[3]) || (strobe_in_done && i == last);
      sm0     = (i == 0) ? m : 1'($urandom_range(0, 1));
      ti_i    = (i == 0) ? ti0 : 1'($urandom_range(0, 1));
      br      = brv[i];
      end_bit = (i > b[7]);
      rst     = (i == rst_e);
      if (i == rst_e) begin
        tick_check(8'd0, "midreset");
        break;
      end
      tick_check(expv(ph[i], m, shp[i]), "frame");
    end
    rst = 1'b0;
    tx  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx = 1'b1; br = 1'b1; sm0 = 1'b0; ti_i = 1'b0; end_bit = 1'b0;
    tick_check(8'd0, "reset");
    tick_check(8'd0, "reset");
    idle(3);
    run_frame(1'b0, 0, 1'b0, 1'b0, -1, 1'b0);
    idle(3);
    run_frame(1'b1, 0, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    run_frame(1'b0, 1, 1'b1, 1'b1, -1, 1'b0);
    idle(2);
    run_frame(1'b1, 1, 1'b1, 1'b1, -1, 1'b0);
    idle(2);
    run_frame(1'b1, 1, 1'b0, 1'b0, 2, 1'b0);
    idle(2);
    run_frame(1'b0, 0, 1'b0, 1'b0, 4, 1'b0);
    idle(2);
    run_frame(1'b1, 1, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
`ifdef SERIAL_TX_CTRL_TI_GUARD_EN
    tx = 1'b1; ti_i = 1'b1; sm0 = 1'b1; br = 1'b0; end_bit = 1'b0; rst = 1'b0;
    tick_check(8'd0, "guard_drop");
    tx = 1'b0;
    tick_check(8'd0, "guard_drop");
    idle(2);
    run_frame(1'b1, 1, 1'b0, 1'b0, -1, 1'b0);
`else
    run_frame(1'b1, 1, 1'b0, 1'b0, -1, 1'b1);
    idle(2);
    run_frame(1'b0, 1, 1'b0, 1'b0, -1, 1'b1);
`endif
    idle(2);
    for (int f = 0; f < 6; f++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
      idle(int'($urandom_range(1, 4)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
